multdiv_sequencer: RTL and testbench

- Sequences the HI/LO multiply/divide resource for the five-stage MIPS pipeline.
- Accepts one operation per start pulse from the EX stage and models the multi-cycle latency of MULT/MULTU (5 cycles) and DIV/DIVU (10 cycles).
- Drives `busy`, which the pipeline controller uses as MDBusy to stall any multdiv-class instruction in ID.
- Commits HI/LO at completion and honours the CP0 write-disable so that flushed instructions leave no side effects.

---
 rtl/multdiv_defs.sv | 45 ++++
 rtl/multdiv_sequencer_arith.sv | 59 +++++
 rtl/multdiv_sequencer.sv | 131 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_defs.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_defs (package)
// Description : Shared opcode, state and latency constants for the HI/LO
//               multiply/divide sequencer and the EX-stage decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_defs;

   localparam int WIDTH_MDOP = 3;
   localparam int WIDTH_CNT  = 4;

   localparam logic [WIDTH_MDOP-1:0] MD_OP_NONE  = 3'd0;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_MULT  = 3'd1;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_MULTU = 3'd2;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_DIV   = 3'd3;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_DIVU  = 3'd4;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_MTHI  = 3'd5;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_MTLO  = 3'd6;
   localparam logic [WIDTH_MDOP-1:0] MD_OP_RSVD  = 3'd7;

   localparam int MD_MUL_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF = 10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2
   } md_state_t;

   // Reserved encoding 7 behaves as NONE.
   function automatic logic md_op_valid(input logic [WIDTH_MDOP-1:0] op);
      return (op != MD_OP_NONE) && (op != MD_OP_RSVD);
   endfunction

   function automatic logic md_op_is_mul(input logic [WIDTH_MDOP-1:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
   endfunction

   function automatic logic md_op_is_div(input logic [WIDTH_MDOP-1:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_sequencer_arith.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_arith
// Description : Combinational 32x32 multiply and 32/32 divide with signed or
//               unsigned interpretation, plus a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_arith
   import multdiv_defs::*;
(
   input  logic [WIDTH_MDOP-1:0] op,
   input  logic [31:0]           rs_val,
   input  logic [31:0]           rt_val,
   output logic [31:0]           res_hi,
   output logic [31:0]           res_lo,
   output logic                  div_zero
);

   logic        w_is_signed;
   logic        w_is_div;
   logic [63:0] w_a64;
   logic [63:0] w_b64;
   logic [63:0] w_prod;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_b_safe;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q;
   logic [31:0] w_r;

   assign w_is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
   assign w_is_div    = md_op_is_div(op);

   // Low 64 bits of the extended product are correct for both signednesses.
   assign w_a64  = w_is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
   assign w_b64  = w_is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
   assign w_prod = w_a64 * w_b64;

   // Divide on magnitudes; 0x80000000 is its own magnitude when viewed unsigned,
   // which makes 0x80000000 / -1 land on lo=0x80000000, hi=0.
   assign w_a_neg  = w_is_signed & rs_val[31];
   assign w_b_neg  = w_is_signed & rt_val[31];
   assign w_a_mag  = w_a_neg ? (~rs_val + 32'd1) : rs_val;
   assign w_b_mag  = w_b_neg ? (~rt_val + 32'd1) : rt_val;
   assign div_zero = (rt_val == 32'd0);
   assign w_b_safe = div_zero ? 32'd1 : w_b_mag;
   assign w_q_mag  = w_a_mag / w_b_safe;
   assign w_r_mag  = w_a_mag % w_b_safe;
   assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

   assign res_hi = w_is_div ? w_r : w_prod[63:32];
   assign res_lo = w_is_div ? w_q : w_prod[31:0];

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : HI/LO multiply/divide sequencer: latency FSM, busy generation
//               and HI/LO commit with write-disable and divide-by-zero hold.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer
   import multdiv_defs::*;
#(
   parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH_MDOP-1:0] op,
   input  logic [31:0]           rs_val,
   input  logic [31:0]           rt_val,
   input  logic                  dis,
   output logic                  busy,
   output logic [31:0]           hi,
   output logic [31:0]           lo
);

   localparam logic [WIDTH_CNT-1:0] c_mul_cnt = WIDTH_CNT'(MUL_CYCLES);
   localparam logic [WIDTH_CNT-1:0] c_div_cnt = WIDTH_CNT'(DIV_CYCLES);

   md_state_t            r_state;
   md_state_t            w_state_nxt;
   logic [WIDTH_CNT-1:0] r_cnt;
   logic [WIDTH_CNT-1:0] w_cnt_nxt;
   logic                 w_start_eff;
   logic                 w_start_run;
   logic                 w_commit;
   logic [31:0]          r_pend_hi;
   logic [31:0]          r_pend_lo;
   logic                 r_pend_dz;
   logic [31:0]          r_hi;
   logic [31:0]          r_lo;
   logic [31:0]          w_arith_hi;
   logic [31:0]          w_arith_lo;
   logic                 w_arith_dz;

   multdiv_arith u_arith (
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .res_hi   (w_arith_hi),
      .res_lo   (w_arith_lo),
      .div_zero (w_arith_dz)
   );

   assign w_start_eff = start & ~dis & (r_state == MD_IDLE) & md_op_valid(op);
   assign w_start_run = w_start_eff & (md_op_is_mul(op) | md_op_is_div(op));
   assign busy        = w_start_eff | (r_state != MD_IDLE);
   assign hi          = r_hi;
   assign lo          = r_lo;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         MD_IDLE: begin
            if (w_start_eff && md_op_is_mul(op)) begin
               w_state_nxt = MD_MUL;
               w_cnt_nxt   = c_mul_cnt;
            end else if (w_start_eff && md_op_is_div(op)) begin
               w_state_nxt = MD_DIV;
               w_cnt_nxt   = c_div_cnt;
            end
         end
         MD_MUL, MD_DIV: begin
            // The <= guard also recovers from a zero count rather than wrapping.
            if (r_cnt <= WIDTH_CNT'(1)) begin
               w_commit    = 1'b1;
               w_state_nxt = MD_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - WIDTH_CNT'(1);
            end
         end
         default: begin
            w_state_nxt = MD_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_dz <= 1'b0;
      end else if (w_start_run) begin
         r_pend_hi <= w_arith_hi;
         r_pend_lo <= w_arith_lo;
         r_pend_dz <= md_op_is_div(op) & w_arith_dz;
      end
   end

   // A divide by zero runs its full latency but leaves HI/LO untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         if (!r_pend_dz) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else if (w_start_eff && (op == MD_OP_MTHI)) begin
         r_hi <= rs_val;
      end else if (w_start_eff && (op == MD_OP_MTLO)) begin
         r_lo <= rs_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Scoreboard bench for multdiv_sequencer latency and HI/LO results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;
   import multdiv_defs::*;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        dis;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        scoreboard[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   always #5 clk = ~clk;

   multdiv_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .dis    (dis),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   // Reference model of the architectural effect of one accepted op.
   function automatic exp_t model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] ph, input logic [31:0] pl);
      exp_t        e;
      longint      sa, sb, q, r;
      logic [63:0] p;
      e.hi = ph;
      e.lo = pl;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd1: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd3: if (b != 0) begin
            q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0];
         end
         3'd4: if (b != 0) begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
            e.hi = r[31:0]; e.lo = q[31:0];
         end
         3'd5: e.hi = a;
         3'd6: e.lo = a;
         default: ;
      endcase
      return e;
   endfunction

   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      start = 1'b1; op = o; rs_val = a; rt_val = b; dis = 1'b0;
      e = model_op(o, a, b, m_hi, m_lo);
      scoreboard.push_back(e);
   endtask

   task automatic end_start();
      @(posedge clk); #1;
      start = 1'b0; dis = 1'b0;
      op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
   endtask

   // Counts busy cycles from the current one; leaves us at the negedge of the first idle cycle.
   task automatic wait_idle(output int run_cycles, output bit stable);
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      run_cycles = 0;
      stable = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
         run_cycles++;
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n);
      int   cyc;
      bit   stable;
      exp_t e;
      launch(o, a, b);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_start got=%b exp=1", tag, busy); end
      end_start();
      wait_idle(cyc, stable);
      e = scoreboard.pop_front();
      checks++;
      if (cyc != n) begin failures++; $display("FAIL %s run_cycles got=%0d exp=%0d", tag, cyc, n); end
      checks++;
      if (!stable) begin failures++; $display("FAIL %s hilo_changed_during_run got=1 exp=0", tag); end
      checks++;
      if (hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", tag, hi, e.hi); end
      checks++;
      if (lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", tag, lo, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
      @(posedge clk); #1;
   endtask

   task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] v);
      exp_t e;
      launch(o, v, $urandom);
      end_start();
      @(negedge clk);
      e = scoreboard.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
         failures++; $display("FAIL %s hilo got=%h_%h exp=%h_%h", tag, hi, lo, e.hi, e.lo);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b exp=0", tag, busy); end
      m_hi = e.hi; m_lo = e.lo;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; dis = 1'b0; op = '0; rs_val = '0; rt_val = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
      checks++;
      if (hi !== 32'd0) begin failures++; $display("FAIL reset hi got=%h exp=0", hi); end
      checks++;
      if (lo !== 32'd0) begin failures++; $display("FAIL reset lo got=%h exp=0", lo); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      run_op("mult_neg", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, MUL_N);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
         failures++; $display("FAIL mult_neg_const got=%h_%h exp=ffffffff_fffffffa", hi, lo);
      end
      run_op("multu", MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, MUL_N);
      checks++;
      if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
         failures++; $display("FAIL multu_const got=%h_%h exp=00000002_fffffffa", hi, lo);
      end
      for (int i = 0; i < 3; i++) begin
         run_op("mult_rand", MD_OP_MULT, $urandom, $urandom, MUL_N);
         run_op("multu_rand", MD_OP_MULTU, $urandom, $urandom, MUL_N);
      end
   endtask

   task automatic test_div();
      run_op("div_neg", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         failures++; $display("FAIL div_neg_const got=%h_%h exp=ffffffff_fffffffd", hi, lo);
      end
      run_op("divu", MD_OP_DIVU, 32'd7, 32'd2, DIV_N);
      checks++;
      if (hi !== 32'd1 || lo !== 32'd3) begin
         failures++; $display("FAIL divu_const got=%h_%h exp=00000001_00000003", hi, lo);
      end
      run_op("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
      checks++;
      if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
         failures++; $display("FAIL div_ovf_const got=%h_%h exp=00000000_80000000", hi, lo);
      end
      run_op("div_rem_sign", MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_N);
      for (int i = 0; i < 3; i++) begin
         run_op("div_rand", MD_OP_DIV, $urandom, $urandom_range(1, 1000), DIV_N);
         run_op("divu_rand", MD_OP_DIVU, $urandom, $urandom, DIV_N);
      end
   endtask

   task automatic test_divzero();
      move_to("mthi", MD_OP_MTHI, 32'hAAAA_0000);
      move_to("mtlo", MD_OP_MTLO, 32'h0000_5555);
      run_op("div_zero", MD_OP_DIV, 32'd1234, 32'd0, DIV_N);
      checks++;
      if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin
         failures++; $display("FAIL div_zero_hold got=%h_%h exp=aaaa0000_00005555", hi, lo);
      end
      run_op("divu_zero", MD_OP_DIVU, 32'd99, 32'd0, DIV_N);
   endtask

   task automatic test_dis();
      int   cyc;
      bit   stable;
      exp_t e;
      start = 1'b1; dis = 1'b1; op = MD_OP_MULT; rs_val = 32'd5; rt_val = 32'd5;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL dis_start busy got=%b exp=0", busy); end
      end_start();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
         failures++; $display("FAIL dis_no_effect got=%b_%h_%h exp=0_%h_%h", busy, hi, lo, m_hi, m_lo);
      end
      @(posedge clk); #1;
      launch(MD_OP_DIV, 32'd100, 32'd7);
      end_start();
      start = 1'b1; dis = 1'b1; op = MD_OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; dis = 1'b0;
      wait_idle(cyc, stable);
      e = scoreboard.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
         failures++; $display("FAIL dis_during_div got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int   cyc;
      bit   stable;
      exp_t e;
      launch(MD_OP_MULT, 32'd6, 32'd7);
      end_start();
      start = 1'b1; op = MD_OP_MTLO; rs_val = 32'h1234; dis = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL b2b busy_midrun got=%b exp=1", busy); end
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(cyc, stable);
      e = scoreboard.pop_front();
      checks++;
      if (lo !== e.lo || hi !== e.hi) begin
         failures++; $display("FAIL b2b_ignored got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun();
      launch(MD_OP_MULT, 32'd3, 32'd4);
      end_start();
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      scoreboard.delete();
      m_hi = '0; m_lo = '0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++; $display("FAIL reset_midrun got=%b_%h_%h exp=0_0_0", busy, hi, lo);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++; $display("FAIL reset_no_commit got=%b_%h_%h exp=0_0_0", busy, hi, lo);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_divzero();
      test_dis();
      test_back_to_back();
      test_reset_midrun();
      run_op("after_reset", MD_OP_MULTU, 32'd11, 32'd13, MUL_N);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
